spi_ram_ctrl: RTL and testbench

Parametrised RAM backend for the SPI slave. It decodes 2-bit-opcode command words from the SPI receive path into independent write and read address pointers, memory writes, and memory reads. Both pointers can optionally auto-increment for burst transfers. Read data goes back to the SPI transmit path over a valid/ready handshake, and an overrun is flagged when a read arrives before the previous read has been consumed.

---
 rtl/spi_ram_ctrl_if.sv | 38 +++
 rtl/spi_ram_ctrl.sv | 167 ++++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_ctrl_if.sv
// Command/response bundle between the SPI shell and the RAM backend.
// Carries the command word, the read-data handshake and the sticky status flags.
// RAM_PARITY_EN adds the parity_err status line.
interface spi_ram_ctrl_if #(
    parameter int ADDR_SIZE  = 8,
    parameter int DATA_WIDTH = 8
);
    localparam int PAYLOAD_W = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;

    logic [PAYLOAD_W+1:0]  din;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] dout;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  overrun;
    logic                  overrun_clr;
`ifdef RAM_PARITY_EN
    logic                  parity_err;
`endif

    // SPI shell side: issues commands, consumes read data
    modport master (
        output din, rx_valid, tx_ready, overrun_clr,
        input  dout, tx_valid, overrun
`ifdef RAM_PARITY_EN
        , input parity_err
`endif
    );

    // RAM backend side
    modport slave (
        input  din, rx_valid, tx_ready, overrun_clr,
        output dout, tx_valid, overrun
`ifdef RAM_PARITY_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// RAM backend for the SPI slave: decodes 2-bit opcode commands into write/read pointers and RAM accesses.
// Latency: read data and tx_valid are registered on the edge that samples the read command (1 cycle).
// Backpressure: a read arriving while the output slot is occupied and not being drained is dropped and sets overrun.
// Optional build macro RAM_PARITY_EN: stores an even-parity bit per word and flags mismatches on read via parity_err.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_SIZE  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AUTO_INC   = 1
) (
    input  logic          clk,
    input  logic          rst,
    spi_ram_ctrl_if.slave bus
);
    localparam int PAYLOAD_W = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;
`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [MEM_W-1:0]      mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0]  wr_ptr;
    logic [ADDR_SIZE-1:0]  rd_ptr;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  tx_valid_q;
    logic                  overrun_q;

    logic [1:0]            opcode;
    logic [PAYLOAD_W-1:0]  payload;
    logic                  cmd_wr_addr;
    logic                  cmd_wr_data;
    logic                  cmd_rd_addr;
    logic                  cmd_rd_data;
    logic                  slot_free;
    logic                  rd_accept;
    logic                  rd_drop;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic [MEM_W-1:0]      wr_word;
    logic [MEM_W-1:0]      rd_word;

    // Post-increment with wrap; any pointer at or past the last word (including
    // an out-of-range address load) goes back to 0.
    function automatic logic [ADDR_SIZE-1:0] ptr_next(input logic [ADDR_SIZE-1:0] p);
        return (p >= LAST_ADDR) ? '0 : p + ADDR_SIZE'(1);
    endfunction

    assign opcode  = bus.din[PAYLOAD_W+1:PAYLOAD_W];
    assign payload = bus.din[PAYLOAD_W-1:0];

    // Command decode, qualified by the single-cycle rx strobe
    always_comb begin
        cmd_wr_addr = 1'b0;
        cmd_wr_data = 1'b0;
        cmd_rd_addr = 1'b0;
        cmd_rd_data = 1'b0;
        if (bus.rx_valid) begin
            case (opcode)
                OP_WR_ADDR: cmd_wr_addr = 1'b1;
                OP_WR_DATA: cmd_wr_data = 1'b1;
                OP_RD_ADDR: cmd_rd_addr = 1'b1;
                OP_RD_DATA: cmd_rd_data = 1'b1;
                default:    cmd_wr_addr = 1'b0;
            endcase
        end
    end

    // The output slot can take a new word if it is empty or drained this cycle
    assign slot_free   = !tx_valid_q || bus.tx_ready;
    assign rd_accept   = cmd_rd_data && slot_free;
    assign rd_drop     = cmd_rd_data && !slot_free;

    assign wr_in_range = (wr_ptr <= LAST_ADDR);
    assign rd_in_range = (rd_ptr <= LAST_ADDR);

`ifdef RAM_PARITY_EN
    assign wr_word = {^payload[DATA_WIDTH-1:0], payload[DATA_WIDTH-1:0]};
`else
    assign wr_word = payload[DATA_WIDTH-1:0];
`endif

    // Out-of-range reads return zero rather than touching the array
    assign rd_word = rd_in_range ? mem[rd_ptr] : '0;

    // RAM array; contents are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (cmd_wr_data && wr_in_range) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Write pointer: loaded by 00, advanced by 01 when auto-increment is on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (cmd_wr_addr) begin
            wr_ptr <= payload[ADDR_SIZE-1:0];
        end else if (cmd_wr_data && (AUTO_INC != 0)) begin
            wr_ptr <= ptr_next(wr_ptr);
        end
    end

    // Read pointer: loaded by 10, advanced only by an accepted 11
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (cmd_rd_addr) begin
            rd_ptr <= payload[ADDR_SIZE-1:0];
        end else if (rd_accept && (AUTO_INC != 0)) begin
            rd_ptr <= ptr_next(rd_ptr);
        end
    end

    // Output slot: load on accepted read (wins over a same-cycle drain), clear on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
        end else if (rd_accept) begin
            dout_q     <= rd_word[DATA_WIDTH-1:0];
            tx_valid_q <= 1'b1;
        end else if (tx_valid_q && bus.tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    // Sticky overrun: a dropped read sets it, and the set beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (rd_drop) begin
            overrun_q <= 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef RAM_PARITY_EN
    logic parity_err_q;

    // Sticky parity error on an accepted in-range read whose stored word has odd parity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if (rd_accept && rd_in_range && (^rd_word)) begin
            parity_err_q <= 1'b1;
        end else if (bus.overrun_clr) begin
            parity_err_q <= 1'b0;
        end
    end

    assign bus.parity_err = parity_err_q;
`endif

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: two instances (depth 256 and depth 200) driven by the same commands.
// A command-level model predicts outputs and pointers; a negedge process compares every cycle.
// Directed literal checks pin the model on reset, bursts, backpressure, wrap, async reset and parity.
`timescale 1ns/1ps
module tb_spi_ram_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b0;
    logic       overrun_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl_if #(.ADDR_SIZE(8), .DATA_WIDTH(8)) bus0 ();
    spi_ram_ctrl_if #(.ADDR_SIZE(8), .DATA_WIDTH(8)) bus1 ();

    assign bus0.din = din;
    assign bus0.rx_valid = rx_valid;
    assign bus0.tx_ready = tx_ready;
    assign bus0.overrun_clr = overrun_clr;
    assign bus1.din = din;
    assign bus1.rx_valid = rx_valid;
    assign bus1.tx_ready = tx_ready;
    assign bus1.overrun_clr = overrun_clr;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_WIDTH(8), .AUTO_INC(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8), .DATA_WIDTH(8), .AUTO_INC(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    logic [7:0] a_dout [2];
    logic       a_tv   [2];
    logic       a_ov   [2];
    logic [7:0] a_wr   [2];
    logic [7:0] a_rd   [2];
    assign a_dout[0] = bus0.dout;
    assign a_dout[1] = bus1.dout;
    assign a_tv[0]   = bus0.tx_valid;
    assign a_tv[1]   = bus1.tx_valid;
    assign a_ov[0]   = bus0.overrun;
    assign a_ov[1]   = bus1.overrun;
    assign a_wr[0]   = dut0.wr_ptr;
    assign a_wr[1]   = dut1.wr_ptr;
    assign a_rd[0]   = dut0.rd_ptr;
    assign a_rd[1]   = dut1.rd_ptr;
`ifdef RAM_PARITY_EN
    logic a_pe [2];
    assign a_pe[0] = bus0.parity_err;
    assign a_pe[1] = bus1.parity_err;
`endif

    // Command-level model state
    int m_mem  [2][256];
    bit m_bad  [2][256];
    int m_wr   [2];
    int m_rd   [2];
    int m_dout [2];
    bit m_tv   [2];
    bit m_ov   [2];
    bit m_pe   [2];

    function automatic int depth_of(input int k);
        return (k == 0) ? 256 : 200;
    endfunction

    function automatic int advance(input int p, input int d);
        return (p >= d - 1) ? 0 : p + 1;
    endfunction

    task automatic model_step(input int k);
        int  d;
        int  op;
        int  pl;
        bit  free;
        bit  set_ov;
        bit  set_pe;
        d      = depth_of(k);
        op     = int'(din[9:8]);
        pl     = int'(din[7:0]);
        free   = !m_tv[k] || tx_ready;
        set_ov = 1'b0;
        set_pe = 1'b0;
        if (m_tv[k] && tx_ready) m_tv[k] = 1'b0;
        if (rx_valid) begin
            case (op)
                0: m_wr[k] = pl;
                1: begin
                    if (m_wr[k] < d) begin
                        m_mem[k][m_wr[k]] = pl;
                        m_bad[k][m_wr[k]] = 1'b0;
                    end
                    m_wr[k] = advance(m_wr[k], d);
                end
                2: m_rd[k] = pl;
                default: begin
                    if (free) begin
                        if (m_rd[k] < d) begin
                            m_dout[k] = m_mem[k][m_rd[k]];
                            if (m_bad[k][m_rd[k]]) set_pe = 1'b1;
                        end else begin
                            m_dout[k] = 0;
                        end
                        m_tv[k] = 1'b1;
                        m_rd[k] = advance(m_rd[k], d);
                    end else begin
                        set_ov = 1'b1;
                    end
                end
            endcase
        end
        if (set_ov) m_ov[k] = 1'b1;
        else if (overrun_clr) m_ov[k] = 1'b0;
        if (set_pe) m_pe[k] = 1'b1;
        else if (overrun_clr) m_pe[k] = 1'b0;
    endtask

    // Model advances on the same edges as the DUT, resets immediately with it
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_wr[k] = 0; m_rd[k] = 0; m_dout[k] = 0;
                m_tv[k] = 1'b0; m_ov[k] = 1'b0; m_pe[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dut%0d.tx_valid", k), int'(a_tv[k]), int'(m_tv[k]));
                chk($sformatf("dut%0d.overrun", k), int'(a_ov[k]), int'(m_ov[k]));
                chk($sformatf("dut%0d.dout", k), int'(a_dout[k]), m_dout[k]);
                chk($sformatf("dut%0d.wr_ptr", k), int'(a_wr[k]), m_wr[k]);
                chk($sformatf("dut%0d.rd_ptr", k), int'(a_rd[k]), m_rd[k]);
`ifdef RAM_PARITY_EN
                chk($sformatf("dut%0d.parity_err", k), int'(a_pe[k]), int'(m_pe[k]));
`endif
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] pl);
        @(posedge clk); #1;
        din = {op, pl};
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit prev;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("reset dout", int'(bus0.dout), 0);
        chk("reset tx_valid", int'(bus0.tx_valid), 0);
        chk("reset overrun", int'(bus0.overrun), 0);
        chk("reset wr_ptr", int'(dut0.wr_ptr), 0);
        chk("reset rd_ptr", int'(dut0.rd_ptr), 0);

        // Address load then two auto-incremented writes
        send(2'b00, 8'h10);
        send(2'b01, 8'hA5);
        send(2'b01, 8'h3C);
        chk("wr mem[0x10]", int'(dut0.mem[16][7:0]), 'hA5);
        chk("wr mem[0x11]", int'(dut0.mem[17][7:0]), 'h3C);
        chk("wr wr_ptr", int'(dut0.wr_ptr), 'h12);

        // Burst read with tx_ready held high
        tx_ready = 1'b1;
        send(2'b10, 8'h10);
        send(2'b11, 8'h00);
        chk("burst dout0", int'(bus0.dout), 'hA5);
        chk("burst tv0", int'(bus0.tx_valid), 1);
        send(2'b11, 8'h00);
        chk("burst dout1", int'(bus0.dout), 'h3C);
        chk("burst tv1", int'(bus0.tx_valid), 1);
        chk("burst rd_ptr", int'(dut0.rd_ptr), 'h12);
        chk("burst overrun", int'(bus0.overrun), 0);

        // Backpressure: pending read blocks a second one
        @(posedge clk); #1 tx_ready = 1'b0;
        send(2'b10, 8'h10);
        send(2'b11, 8'h00);
        send(2'b11, 8'h00);
        chk("bp dout held", int'(bus0.dout), 'hA5);
        chk("bp overrun", int'(bus0.overrun), 1);
        chk("bp rd_ptr", int'(dut0.rd_ptr), 'h11);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        din = {2'b11, 8'h00};
        rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        chk("bp accept+read tv", int'(bus0.tx_valid), 1);
        chk("bp accept+read dout", int'(bus0.dout), 'h3C);
        chk("bp rd_ptr after", int'(dut0.rd_ptr), 'h12);
        overrun_clr = 1'b1;
        @(posedge clk); #1 overrun_clr = 1'b0;
        chk("overrun cleared", int'(bus0.overrun), 0);

        // Wrap at depth 200 and out-of-range accesses
        send(2'b00, 8'd199);
        send(2'b01, 8'h77);
        chk("wrap mem[199]", int'(dut1.mem[199][7:0]), 'h77);
        chk("wrap wr_ptr d200", int'(dut1.wr_ptr), 0);
        chk("wrap wr_ptr d256", int'(dut0.wr_ptr), 200);
        send(2'b00, 8'd250);
        send(2'b01, 8'h55);
        chk("oor wr_ptr d200", int'(dut1.wr_ptr), 0);
        chk("oor mem[250] d256", int'(dut0.mem[250][7:0]), 'h55);
        send(2'b10, 8'd250);
        send(2'b11, 8'h00);
        chk("oor read dout d200", int'(bus1.dout), 0);
        chk("oor read tv d200", int'(bus1.tx_valid), 1);
        chk("oor rd_ptr d200", int'(dut1.rd_ptr), 0);
        chk("oor read dout d256", int'(bus0.dout), 'h55);

        // Async reset in mid-cycle with a pending read and overrun set
        tx_ready = 1'b0;
        send(2'b11, 8'h00);
        chk("pre-reset overrun", int'(bus0.overrun), 1);
        chk("pre-reset tv", int'(bus0.tx_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst tv", int'(bus0.tx_valid), 0);
        chk("arst dout", int'(bus0.dout), 0);
        chk("arst overrun", int'(bus0.overrun), 0);
        chk("arst wr_ptr", int'(dut0.wr_ptr), 0);
        chk("arst rd_ptr", int'(dut0.rd_ptr), 0);
        chk("arst tv d200", int'(bus1.tx_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tx_ready = 1'b1;

`ifdef RAM_PARITY_EN
        // Corrupt the stored parity of word 5 and read it back
        send(2'b00, 8'd5);
        send(2'b01, 8'h5A);
        dut0.mem[5][8] = ~dut0.mem[5][8];
        dut1.mem[5][8] = ~dut1.mem[5][8];
        m_bad[0][5] = 1'b1;
        m_bad[1][5] = 1'b1;
        send(2'b10, 8'd5);
        send(2'b11, 8'h00);
        chk("parity_err set", int'(bus0.parity_err), 1);
        chk("parity dout", int'(bus0.dout), 'h5A);
        overrun_clr = 1'b1;
        @(posedge clk); #1 overrun_clr = 1'b0;
        chk("parity_err cleared", int'(bus0.parity_err), 0);
`endif

        // Fill every word so random reads see defined contents
        send(2'b00, 8'd0);
        for (int i = 0; i < 256; i++) send(2'b01, 8'($urandom));

        // Randomized traffic with random backpressure and clears
        prev = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            tx_ready    = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 15) == 0);
            if (!prev && ($urandom_range(0, 1) == 1)) begin
                din      = 10'($urandom);
                rx_valid = 1'b1;
                prev     = 1'b1;
            end else begin
                rx_valid = 1'b0;
                prev     = 1'b0;
            end
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
